spi_burst_ctrl: RTL and testbench
=================================

# spi_burst_ctrl

Sequencer that drives the SPI master's register bus (`Addr`/`Wr`/`DataWr`/`DataRd`) on behalf of a streaming client. It accepts one burst command (slave, mode, prescaler, byte count) and streams TX bytes in and RX bytes out over valid/ready handshakes. For every byte it performs the register writes, start, completion poll and readback. It sits directly upstream of the SPI master top, in the same clock domain.

## Interface
- `MAX_LEN`, 16: maximum bytes per burst; `CmdLen` is 4 bits and encodes length−1.
- `Clk` in 1: system clock; all logic on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `CmdValid` in 1: a burst command is presented.
- `CmdReady` out 1: high only in IDLE.
- `CmdSlave` in 3: slave index 0..7.
- `CmdCPol` in 1, `CmdCPha` in 1, `CmdCPre` in 4: SPI mode and prescaler.
- `CmdLen` in 4: number of bytes −1.
- `TxValid` in 1, `TxReady` out 1, `TxData` in 8: TX byte stream.
- `RxValid` out 1, `RxReady` in 1, `RxData` out 8: RX byte stream.
- `Busy` out 1: high from command acceptance until return to IDLE.
- `Done` out 1: one-cycle pulse on burst completion.
- `SpiAddr` out 2, `SpiWr` out 1, `SpiDataWr` out 8: register bus to the SPI master.
- `SpiDataRd` in 8: register readback from the SPI master.

## Operation
- SPI master register map:
  - 0 = CTRL. Write: b0 CPol, b1 CPha, b5:2 CPre, b7 StartTx. Read: b0 EndTx.
  - 1 = TXDATA.
  - 2 = RXDATA.
  - 3 = SS, active-low one-hot; idle value is 8'hFF.
- Command accept: on `CmdValid & CmdReady`, latch all command fields, load byte counter = `CmdLen`, then go to SEL.
- State sequence:
  - SEL: write SS = ~(1<<slave).
  - CFG: write CTRL = {0,0,CPre,CPha,CPol}.
  - TXW: `TxReady`=1; on `TxValid`, write TXDATA = `TxData` in the same cycle.
  - START: write CTRL with b7=1.
  - POLL: `SpiAddr`=0, no write; leave when sampled `SpiDataRd[0]`=1.
  - RDA: `SpiAddr`=2.
  - RDL: latch `SpiDataRd` into the RX register, raise `RxValid`.
  - PUSH: hold `RxValid` until `RxReady`. Then, if counter=0, go to DESEL; otherwise decrement the counter and go to CFG, which clears StartTx.
  - DESEL: write SS = 8'hFF.
  - FIN: pulse `Done`, go to IDLE.
- `SpiWr` is high only for a single cycle in SEL, CFG, the TXW handshake cycle, START and DESEL.
- `SpiAddr` is held stable in POLL, RDA and RDL. `SpiDataRd` is sampled one cycle after `SpiAddr` changes, which tolerates a registered read path.
- `TxReady` is high only in TXW. `RxValid` and `RxData` are stable until accepted (AXI-style: never drop valid without a handshake).
- No timeout in POLL; a hung master holds `Busy`. A `CmdValid` while busy is ignored (`CmdReady`=0).

## Timing
- Reset values: state IDLE, `CmdReady`=1, `TxReady`=0, `RxValid`=0, `RxData`=0, `Busy`=0, `Done`=0, `SpiWr`=0, `SpiAddr`=0, `SpiDataWr`=0.
- Reset mid-burst forces IDLE immediately. SS is not rewritten; the SPI master is reset by the same system reset.
- Per-byte overhead, excluding the SPI shift time: CFG, TXW (≥1), START, POLL (≥2), RDA, RDL, PUSH (≥1), i.e. a minimum of 8 cycles.
- Burst overhead: SEL + DESEL + FIN, i.e. 3 cycles.
- POLL: the first cycle only sets the address; the EndTx sample is valid from the second cycle. EndTx samples taken earlier than 2 cycles after START are ignored, so a stale EndTx from the previous byte is never seen.
- `Done` is asserted in the FIN cycle; `CmdReady` rises the following cycle.
- Counter wrap: `CmdLen`=15 gives exactly 16 bytes; the counter never underflows.

## Structure
- Shared package holds:
  - SPI register address constants (CTRL/TXDATA/RXDATA/SS).
  - CTRL bit positions (CPOL, CPHA, CPRE_LSB, START) and the EndTx bit position.
  - The SS idle value 8'hFF.
  - The state encoding typedef.
- Single module with no sub-module; the FSM, counter and RX holding register are all local.

## Test plan
- Reset mid-burst: assert `Rst` during POLL -> all outputs at reset values in the same cycle; `Busy`=0; a new command is accepted after release.
- Single byte, mode 0, CPre 3, slave 2, TX 8'hA5, MISO loopback -> SS writes 8'hFB then 8'hFF; `RxData`=8'hA5; one `Done` pulse.
- 16-byte burst (`CmdLen`=15), TX 0x00..0x0F, loopback -> 16 RX bytes in order, exactly 16 START writes.
- Backpressure: `TxValid` gapped 5 cycles and `RxReady` low 10 cycles per byte -> no TXDATA write without a handshake; `RxData` stable while `RxValid`=1 and `RxReady`=0.
- Mode sweep with CPol/CPha = 1/1 and CPre 0 -> CTRL write = 8'h03, START write = 8'h83.
- `CmdValid` held high during a burst -> second command accepted only after `Done`, in the cycle `CmdReady` returns to 1.

Source files
------------

// File: rtl/spi_burst_ctrl_pkg.sv
// Shared definitions for the SPI burst sequencer: SPI master register map,
// CTRL/status bit positions and the sequencer state encoding.
package spi_burst_ctrl_pkg;

  localparam logic [1:0] SPI_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] SPI_ADDR_TXDATA = 2'd1;
  localparam logic [1:0] SPI_ADDR_RXDATA = 2'd2;
  localparam logic [1:0] SPI_ADDR_SS     = 2'd3;

  localparam int CTRL_CPOL     = 0;
  localparam int CTRL_CPHA     = 1;
  localparam int CTRL_CPRE_LSB = 2;
  localparam int CTRL_START    = 7;
  localparam int STAT_END_TX   = 0;

  localparam logic [7:0] SS_IDLE = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEL,
    ST_CFG,
    ST_TXW,
    ST_START,
    ST_POLL,
    ST_RDA,
    ST_RDL,
    ST_PUSH,
    ST_DESEL,
    ST_FIN
  } state_e;

  function automatic logic [7:0] ctrl_word(input logic       cpol,
                                           input logic       cpha,
                                           input logic [3:0] cpre,
                                           input logic       start);
    logic [7:0] w;
    w                      = '0;
    w[CTRL_CPOL]           = cpol;
    w[CTRL_CPHA]           = cpha;
    w[CTRL_CPRE_LSB +: 4]  = cpre;
    w[CTRL_START]          = start;
    return w;
  endfunction

  // Slave selects are active-low one-hot.
  function automatic logic [7:0] ss_select(input logic [2:0] slave);
    return ~(8'd1 << slave);
  endfunction

endpackage

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer driving the SPI master register bus: per byte it configures,
// loads TXDATA, starts, polls EndTx, reads RXDATA and hands the byte downstream.
module spi_burst_ctrl
  import spi_burst_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       CmdValid,
  output logic                       CmdReady,
  input  logic [2:0]                 CmdSlave,
  input  logic                       CmdCPol,
  input  logic                       CmdCPha,
  input  logic [3:0]                 CmdCPre,
  input  logic [$clog2(MAX_LEN)-1:0] CmdLen,
  input  logic                       TxValid,
  output logic                       TxReady,
  input  logic [7:0]                 TxData,
  output logic                       RxValid,
  input  logic                       RxReady,
  output logic [7:0]                 RxData,
  output logic                       Busy,
  output logic                       Done,
  output logic [1:0]                 SpiAddr,
  output logic                       SpiWr,
  output logic [7:0]                 SpiDataWr,
  input  logic [7:0]                 SpiDataRd
);

  localparam int                CNT_W   = $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       slave_q, slave_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [3:0]       cpre_q, cpre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             poll_armed_q, poll_armed_d;
  logic [7:0]       rx_data_q, rx_data_d;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      slave_q      <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      cpre_q       <= '0;
      cnt_q        <= '0;
      poll_armed_q <= 1'b0;
      rx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      slave_q      <= slave_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      cpre_q       <= cpre_d;
      cnt_q        <= cnt_d;
      poll_armed_q <= poll_armed_d;
      rx_data_q    <= rx_data_d;
    end
  end

  assign RxData = rx_data_q;

  always_comb begin
    state_d      = state_q;
    slave_d      = slave_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    cpre_d       = cpre_q;
    cnt_d        = cnt_q;
    rx_data_d    = rx_data_q;
    // EndTx read back in the first POLL cycle still reflects the previous byte.
    poll_armed_d = (state_q == ST_POLL);

    CmdReady  = 1'b0;
    TxReady   = 1'b0;
    RxValid   = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    SpiWr     = 1'b0;
    SpiAddr   = SPI_ADDR_CTRL;
    SpiDataWr = '0;

    case (state_q)
      ST_IDLE: begin
        Busy     = 1'b0;
        CmdReady = 1'b1;
        if (CmdValid) begin
          slave_d = CmdSlave;
          cpol_d  = CmdCPol;
          cpha_d  = CmdCPha;
          cpre_d  = CmdCPre;
          cnt_d   = CmdLen;
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        SpiWr     = 1'b1;
        SpiAddr   = SPI_ADDR_SS;
        SpiDataWr = ss_select(slave_q);
        state_d   = ST_CFG;
      end
      ST_CFG: begin
        SpiWr     = 1'b1;
        SpiDataWr = ctrl_word(cpol_q, cpha_q, cpre_q, 1'b0);
        state_d   = ST_TXW;
      end
      ST_TXW: begin
        TxReady = 1'b1;
        SpiAddr = SPI_ADDR_TXDATA;
        if (TxValid) begin
          SpiWr     = 1'b1;
          SpiDataWr = TxData;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        SpiWr     = 1'b1;
        SpiDataWr = ctrl_word(cpol_q, cpha_q, cpre_q, 1'b1);
        state_d   = ST_POLL;
      end
      ST_POLL: begin
        if (poll_armed_q && SpiDataRd[STAT_END_TX]) begin
          state_d = ST_RDA;
        end
      end
      ST_RDA: begin
        SpiAddr = SPI_ADDR_RXDATA;
        state_d = ST_RDL;
      end
      ST_RDL: begin
        SpiAddr   = SPI_ADDR_RXDATA;
        rx_data_d = SpiDataRd;
        state_d   = ST_PUSH;
      end
      ST_PUSH: begin
        RxValid = 1'b1;
        if (RxReady) begin
          if (cnt_q == '0) begin
            state_d = ST_DESEL;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
            state_d = ST_CFG;
          end
        end
      end
      ST_DESEL: begin
        SpiWr     = 1'b1;
        SpiAddr   = SPI_ADDR_SS;
        SpiDataWr = SS_IDLE;
        state_d   = ST_FIN;
      end
      ST_FIN: begin
        Done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl with a behavioural SPI master (registered
// read path, loopback MISO) answering on the register bus.
module tb_spi_burst_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       CmdValid = 1'b0;
  logic       CmdReady;
  logic [2:0] CmdSlave = '0;
  logic       CmdCPol = 1'b0;
  logic       CmdCPha = 1'b0;
  logic [3:0] CmdCPre = '0;
  logic [3:0] CmdLen = '0;
  logic       TxValid = 1'b0;
  logic       TxReady;
  logic [7:0] TxData = '0;
  logic       RxValid;
  logic       RxReady = 1'b1;
  logic [7:0] RxData;
  logic       Busy;
  logic       Done;
  logic [1:0] SpiAddr;
  logic       SpiWr;
  logic [7:0] SpiDataWr;
  logic [7:0] SpiDataRd;

  always #5 Clk = ~Clk;

  spi_burst_ctrl #(.MAX_LEN(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdSlave(CmdSlave),
    .CmdCPol(CmdCPol), .CmdCPha(CmdCPha), .CmdCPre(CmdCPre), .CmdLen(CmdLen),
    .TxValid(TxValid), .TxReady(TxReady), .TxData(TxData),
    .RxValid(RxValid), .RxReady(RxReady), .RxData(RxData),
    .Busy(Busy), .Done(Done),
    .SpiAddr(SpiAddr), .SpiWr(SpiWr), .SpiDataWr(SpiDataWr), .SpiDataRd(SpiDataRd)
  );

  // SPI master model: registered readback, 3-cycle shift, MISO looped to MOSI.
  logic [7:0] m_tx, m_rx, m_ss, m_rd;
  logic       m_end;
  int         m_busy;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_tx <= '0; m_rx <= '0; m_ss <= 8'hFF; m_end <= 1'b1; m_busy <= 0; m_rd <= '0;
    end else begin
      case (SpiAddr)
        2'd0:    m_rd <= {7'b0, m_end};
        2'd1:    m_rd <= m_tx;
        2'd2:    m_rd <= m_rx;
        default: m_rd <= m_ss;
      endcase
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_end <= 1'b1;
          m_rx  <= m_tx;
        end
      end
      if (SpiWr) begin
        case (SpiAddr)
          2'd0: if (SpiDataWr[7]) begin m_end <= 1'b0; m_busy <= 3; end
          2'd1: m_tx <= SpiDataWr;
          2'd3: m_ss <= SpiDataWr;
          default: ;
        endcase
      end
    end
  end
  assign SpiDataRd = m_rd;

  logic [9:0] exp_wr[$];
  logic [7:0] exp_rx[$];
  int exp_done = 0;
  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int cyc = 0;
  int done_cyc = 0;
  logic rx_bp = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %0h expected none", name, act);
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // RX sink: always ready, or under backpressure ~10 cycles low per byte.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge Clk);
      #1;
      if (!rx_bp) begin
        RxReady = 1'b1;
      end else if (RxValid && !RxReady) begin
        hold++;
        if (hold >= 10) RxReady = 1'b1;
      end else begin
        RxReady = 1'b0;
        hold = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes, delivers or finishes.
  initial begin
    logic       prev_v, prev_r;
    logic [7:0] prev_d;
    logic [9:0] e;
    logic [7:0] er;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        prev_v = 1'b0;
      end else begin
        if (SpiWr) begin
          if (SpiAddr == 2'd1) check_output("tx_handshake", {31'b0, TxValid && TxReady}, 32'd1);
          if (SpiAddr == 2'd0 && SpiDataWr[7]) start_cnt++;
          if (exp_wr.size() == 0) report_fail("unexpected_wr", {22'b0, SpiAddr, SpiDataWr});
          else begin
            e = exp_wr.pop_front();
            check_output("spi_wr", {22'b0, SpiAddr, SpiDataWr}, {22'b0, e});
          end
        end
        if (prev_v && !prev_r) begin
          check_output("rx_valid_hold", {31'b0, RxValid}, 32'd1);
          check_output("rx_data_hold", {24'b0, RxData}, {24'b0, prev_d});
        end
        if (RxValid && RxReady) begin
          if (exp_rx.size() == 0) report_fail("unexpected_rx", {24'b0, RxData});
          else begin
            er = exp_rx.pop_front();
            check_output("rx_data", {24'b0, RxData}, {24'b0, er});
          end
        end
        if (Done) begin
          done_cyc = cyc;
          if (exp_done == 0) report_fail("unexpected_done", 32'd1);
          else begin
            exp_done--;
            check_output("done_busy", {31'b0, Busy}, 32'd1);
            check_output("done_cmdready", {31'b0, CmdReady}, 32'd0);
          end
        end
        prev_v = RxValid;
        prev_r = RxReady;
        prev_d = RxData;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_cmdready"}, {31'b0, CmdReady}, 32'd1);
    check_output({tag, "_txready"},  {31'b0, TxReady},  32'd0);
    check_output({tag, "_rxvalid"},  {31'b0, RxValid},  32'd0);
    check_output({tag, "_rxdata"},   {24'b0, RxData},   32'd0);
    check_output({tag, "_busy"},     {31'b0, Busy},     32'd0);
    check_output({tag, "_done"},     {31'b0, Done},     32'd0);
    check_output({tag, "_spiwr"},    {31'b0, SpiWr},    32'd0);
    check_output({tag, "_spiaddr"},  {30'b0, SpiAddr},  32'd0);
    check_output({tag, "_spidatawr"},{24'b0, SpiDataWr},32'd0);
  endtask

  task automatic push_burst(input logic [7:0] ss, input logic [7:0] ctrl, input logic [7:0] start,
                            input logic [7:0] first_tx, input int nbytes);
    logic [7:0] b;
    exp_wr.push_back({2'd3, ss});
    for (int i = 0; i < nbytes; i++) begin
      b = first_tx + 8'(i);
      exp_wr.push_back({2'd0, ctrl});
      exp_wr.push_back({2'd1, b});
      exp_wr.push_back({2'd0, start});
      exp_rx.push_back(b);
    end
    exp_wr.push_back({2'd3, 8'hFF});
    exp_done++;
  endtask

  task automatic issue_cmd(input logic [2:0] slave, input logic cpol, input logic cpha,
                           input logic [3:0] cpre, input logic [3:0] len);
    int t;
    @(posedge Clk); #1;
    CmdValid = 1'b1; CmdSlave = slave; CmdCPol = cpol; CmdCPha = cpha; CmdCPre = cpre; CmdLen = len;
    t = 0;
    do begin @(negedge Clk); t++; end while (!CmdReady && t < 2000);
    if (!CmdReady) report_fail("cmd_timeout", 32'd0);
    @(posedge Clk); #1;
    CmdValid = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] d, input int gap);
    int t;
    repeat (gap) @(posedge Clk);
    #1;
    TxValid = 1'b1; TxData = d;
    t = 0;
    do begin @(negedge Clk); t++; end while (!TxReady && t < 2000);
    if (!TxReady) report_fail("tx_timeout", {24'b0, d});
    @(posedge Clk); #1;
    TxValid = 1'b0;
  endtask

  task automatic wait_bursts();
    int t;
    t = 0;
    while (exp_done > 0 && t < 5000) begin @(posedge Clk); t++; end
    if (exp_done > 0) report_fail("done_timeout", exp_done);
    check_output("wr_queue_empty", exp_wr.size(), 32'd0);
    check_output("rx_queue_empty", exp_rx.size(), 32'd0);
  endtask

  task automatic apply_stimulus(input logic [2:0] slave, input logic cpol, input logic cpha,
                                input logic [3:0] cpre, input logic [3:0] len,
                                input logic [7:0] ss, input logic [7:0] ctrl, input logic [7:0] start,
                                input logic [7:0] first_tx, input int gap);
    push_burst(ss, ctrl, start, first_tx, int'(len) + 1);
    issue_cmd(slave, cpol, cpha, cpre, len);
    for (int i = 0; i <= int'(len); i++) send_tx(first_tx + 8'(i), gap);
    wait_bursts();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0, t, acc_cyc;
    repeat (3) @(negedge Clk);
    check_reset_outputs("in_reset");
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check_reset_outputs("after_reset");

    $display("[TB] single byte mode 0 cpre 3 slave 2");
    apply_stimulus(3'd2, 1'b0, 1'b0, 4'd3, 4'd0, 8'hFB, 8'h0C, 8'h8C, 8'hA5, 0);

    $display("[TB] mode 1/1 cpre 0 slave 7");
    apply_stimulus(3'd7, 1'b1, 1'b1, 4'd0, 4'd0, 8'h7F, 8'h03, 8'h83, 8'h3C, 0);

    $display("[TB] 16-byte burst");
    s0 = start_cnt;
    apply_stimulus(3'd0, 1'b0, 1'b0, 4'd1, 4'd15, 8'hFE, 8'h04, 8'h84, 8'h00, 0);
    check_output("start_writes_16", start_cnt - s0, 32'd16);

    $display("[TB] backpressure");
    rx_bp = 1'b1;
    apply_stimulus(3'd4, 1'b1, 1'b0, 4'd15, 4'd2, 8'hEF, 8'h3D, 8'hBD, 8'h5A, 5);
    rx_bp = 1'b0;

    $display("[TB] CmdValid held through a burst");
    push_burst(8'hFD, 8'h0A, 8'h8A, 8'h11, 1);
    push_burst(8'hDF, 8'h00, 8'h80, 8'h22, 2);
    @(posedge Clk); #1;
    CmdValid = 1'b1; CmdSlave = 3'd1; CmdCPol = 1'b0; CmdCPha = 1'b1; CmdCPre = 4'd2; CmdLen = 4'd0;
    t = 0;
    do begin @(negedge Clk); t++; end while (!CmdReady && t < 2000);
    @(posedge Clk); #1;
    CmdSlave = 3'd5; CmdCPol = 1'b0; CmdCPha = 1'b0; CmdCPre = 4'd0; CmdLen = 4'd1;
    send_tx(8'h11, 0);
    t = 0;
    do begin @(negedge Clk); t++; end while (!CmdReady && t < 2000);
    acc_cyc = cyc;
    if (!CmdReady) report_fail("second_cmd_timeout", 32'd0);
    @(posedge Clk); #1;
    CmdValid = 1'b0;
    check_output("accept_after_done", acc_cyc, done_cyc + 1);
    send_tx(8'h22, 0);
    send_tx(8'h23, 0);
    wait_bursts();

    $display("[TB] reset during POLL");
    push_burst(8'hF7, 8'h00, 8'h80, 8'h77, 1);
    issue_cmd(3'd3, 1'b0, 1'b0, 4'd0, 4'd0);
    s0 = start_cnt;
    send_tx(8'h77, 0);
    t = 0;
    while (start_cnt == s0 && t < 2000) begin @(posedge Clk); t++; end
    if (start_cnt == s0) report_fail("start_timeout", 32'd0);
    #3;
    Rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    exp_wr.delete();
    exp_rx.delete();
    exp_done = 0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    apply_stimulus(3'd6, 1'b0, 1'b0, 4'd0, 4'd0, 8'hBF, 8'h00, 8'h80, 8'h99, 0);

    repeat (3) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
